mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multi-cycle main control FSM that sequences the single-cycle-style MIPS datapath through fetch, decode, execute, memory and writeback steps.
- Drives the datapath's control inputs (ALU op, source selects, register write, memory-to-register) plus PC/IR enables and the memory request.
- Sits between the instruction register (opcode/funct fields) and the datapath. It also handles a shared instruction/data memory with a ready handshake.

Parameters:
- MEM_WAIT_MAX, 15, cycles a memory request may wait for mem_ready before the FSM aborts to FETCH and flags timeout (0 disables the timeout).

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- iord  out  1  0 = memory address from PC, 1 = from ALU result register
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  1  load instruction register
- pcen  out  1  PC load enable
- pcsrc  out  2  00 = ALU result, 01 = ALU-out register (branch target), 10 = jump target
- regwrite  out  1  register file write enable
- regdst  out  1  0 = rt, 1 = rd
- mem2reg  out  1  writeback source 1 = memory data
- alusrca  out  1  0 = PC, 1 = rs
- alusrcb  out  2  00 = rt, 01 = const 4, 10 = signimm, 11 = signimm<<2
- op  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
- state  out  4  current state code (debug)
- illegal  out  1  one-cycle pulse on unsupported opcode/funct
- timeout  out  1  one-cycle pulse on memory wait expiry

Behaviour:

State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.

Reset:
- While rst=1, all outputs are forced to 0, including op=000.
- Next state after rst is FETCH and the wait counter is cleared.
- rst asserted mid-instruction abandons it; no write strobe is asserted during the reset cycle.

Outputs:
- Moore outputs depend on state only. Exceptions: pcen and irwrite, which also depend on mem_ready/zero.
- Any output not listed for a state is 0.

FETCH:
- Outputs: memread=1, iord=0, alusrca=0, alusrcb=01, op=010, pcsrc=00.
- irwrite=pcen=mem_ready.
- Stays in FETCH until mem_ready=1, then goes to DECODE.

DECODE:
- Outputs: alusrca=0, alusrcb=11, op=010 (computes the branch target).
- Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> EXEC
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
- Any other opcode: pulse illegal and go to FETCH.

MEMADR:
- Outputs: alusrca=1, alusrcb=10, op=010.
- Next state is MEMRD for lw, MEMWR for sw.

MEMRD:
- Outputs: memread=1, iord=1.
- Waits for mem_ready, then goes to MEMWB.

MEMWB:
- Outputs: regwrite=1, regdst=0, mem2reg=1.
- Next state FETCH.

MEMWR:
- Outputs: memwrite=1, iord=1.
- Waits for mem_ready, then goes to FETCH.

EXEC:
- Outputs: alusrca=1, alusrcb=00, op from funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
- Next state ALUWB. Any other funct: pulse illegal and go to FETCH (no ALUWB).

ALUWB:
- Outputs: regwrite=1, regdst=1, mem2reg=0.
- Next state FETCH.

BRANCH:
- Outputs: alusrca=1, alusrcb=00, op=110, pcsrc=01, pcen=zero.
- Next state FETCH.

ADDIEX:
- Outputs: alusrca=1, alusrcb=10, op=010.
- Next state ADDIWB.

ADDIWB:
- Outputs: regwrite=1, regdst=0, mem2reg=0.
- Next state FETCH.

JUMP:
- Outputs: pcsrc=10, pcen=1.
- Next state FETCH.

Memory handshake:
- memread/memwrite are held constant, with iord stable, until the cycle mem_ready=1.
- The transfer completes in that cycle and the request drops in the next state.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

Wait counter (4-bit, saturating at 15):
- Cleared on entry to each memory state.
- Increments each waiting cycle.
- When MEM_WAIT_MAX!=0 and count==MEM_WAIT_MAX with mem_ready=0: pulse timeout, drop the request, go to FETCH.
- A timeout in FETCH does not assert pcen or irwrite.

Latency in cycles with zero-wait memory (mem_ready tied 1): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Test Plan:
- rst=1 for 2 cycles mid-EXEC -> all outputs 0 during rst; state=0 after release; memread=1 next cycle.
- lw (opcode 100011), mem_ready=1 -> states 0,1,2,3,4; regwrite=1 and mem2reg=1 only in state 4; 5 cycles total.
- R-type sub (funct 100010) -> op=110 in EXEC; regwrite=1 and regdst=1 in ALUWB; back to FETCH.
- beq with zero=1 then zero=0 -> pcen=1 and pcsrc=01 in BRANCH for the first, pcen=0 for the second; both 3 cycles.
- sw with mem_ready low 3 cycles -> memwrite=1 and iord=1 held 4 cycles; returns to FETCH after the ready cycle. Repeat with mem_ready never high, MEM_WAIT_MAX=15 -> timeout pulse after 15 wait cycles, state=0, memwrite=0.
- opcode 111111, then R-type funct 000000 -> illegal pulses 1 cycle each; regwrite is never asserted; FETCH follows.

Source files
------------

// File: rtl/mc_controller_if.sv
// Control bundle between the multi-cycle main controller and the MIPS datapath/memory.
// The master side is the controller; the slave side is the datapath and instruction register.
interface mc_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       pcen;
  logic [1:0] pcsrc;
  logic       regwrite;
  logic       regdst;
  logic       mem2reg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] op;
  logic [3:0] state;
  logic       illegal;
  logic       timeout;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output iord, memread, memwrite, irwrite, pcen, pcsrc, regwrite, regdst,
           mem2reg, alusrca, alusrcb, op, state, illegal, timeout
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  iord, memread, memwrite, irwrite, pcen, pcsrc, regwrite, regdst,
           mem2reg, alusrca, alusrcb, op, state, illegal, timeout
  );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS main control FSM with a shared-memory ready handshake
// and a saturating wait counter that aborts stalled memory requests.
module mc_controller #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic          clk,
  input  logic          rst,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT_MAX);
  localparam bit         WAIT_EN    = (MEM_WAIT_MAX != 0);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;

  logic       iord_c, memread_c, memwrite_c, irwrite_c, pcen_c;
  logic [1:0] pcsrc_c;
  logic       regwrite_c, regdst_c, mem2reg_c, alusrca_c;
  logic [1:0] alusrcb_c;
  logic [2:0] op_c;
  logic       illegal_c, timeout_c;
  logic       mem_state, expired;

  assign mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign expired   = WAIT_EN && mem_state && !bus.mem_ready && (wait_q == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    iord_c     = 1'b0;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    pcen_c     = 1'b0;
    pcsrc_c    = 2'b00;
    regwrite_c = 1'b0;
    regdst_c   = 1'b0;
    mem2reg_c  = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    op_c       = 3'b000;
    illegal_c  = 1'b0;
    timeout_c  = 1'b0;

    case (state_q)
      FETCH: begin
        memread_c = 1'b1;
        alusrcb_c = 2'b01;
        op_c      = ALU_ADD;
        if (bus.mem_ready) begin
          irwrite_c = 1'b1;
          pcen_c    = 1'b1;
          state_d   = DECODE;
        end else if (expired) begin
          timeout_c = 1'b1;
          state_d   = FETCH;
        end
      end
      DECODE: begin
        alusrcb_c = 2'b11;
        op_c      = ALU_ADD;
        case (bus.opcode)
          OPC_LW, OPC_SW: state_d = MEMADR;
          OPC_RTYPE:      state_d = EXEC;
          OPC_BEQ:        state_d = BRANCH;
          OPC_ADDI:       state_d = ADDIEX;
          OPC_J:          state_d = JUMP;
          default: begin
            illegal_c = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        op_c      = ALU_ADD;
        state_d   = (bus.opcode == OPC_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memread_c = 1'b1;
        iord_c    = 1'b1;
        if (bus.mem_ready) begin
          state_d = MEMWB;
        end else if (expired) begin
          timeout_c = 1'b1;
          state_d   = FETCH;
        end
      end
      MEMWB: begin
        regwrite_c = 1'b1;
        mem2reg_c  = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
        if (bus.mem_ready) begin
          state_d = FETCH;
        end else if (expired) begin
          timeout_c = 1'b1;
          state_d   = FETCH;
        end
      end
      EXEC: begin
        alusrca_c = 1'b1;
        state_d   = ALUWB;
        case (bus.funct)
          FN_ADD: op_c = ALU_ADD;
          FN_SUB: op_c = ALU_SUB;
          FN_AND: op_c = ALU_AND;
          FN_OR:  op_c = ALU_OR;
          FN_SLT: op_c = ALU_SLT;
          default: begin
            illegal_c = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      ALUWB: begin
        regwrite_c = 1'b1;
        regdst_c   = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alusrca_c = 1'b1;
        op_c      = ALU_SUB;
        pcsrc_c   = 2'b01;
        pcen_c    = bus.zero;
        state_d   = FETCH;
      end
      ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        op_c      = ALU_ADD;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        regwrite_c = 1'b1;
        state_d    = FETCH;
      end
      JUMP: begin
        pcsrc_c = 2'b10;
        pcen_c  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Counter restarts on every state change and on a timeout retry of FETCH.
  always_comb begin
    wait_d = 4'd0;
    if ((state_d == state_q) && !timeout_c && mem_state) begin
      wait_d = sat_inc(wait_q);
    end
  end

  // Reset forces every output low, including the debug state code.
  assign bus.iord     = iord_c & ~rst;
  assign bus.memread  = memread_c & ~rst;
  assign bus.memwrite = memwrite_c & ~rst;
  assign bus.irwrite  = irwrite_c & ~rst;
  assign bus.pcen     = pcen_c & ~rst;
  assign bus.pcsrc    = rst ? 2'b00 : pcsrc_c;
  assign bus.regwrite = regwrite_c & ~rst;
  assign bus.regdst   = regdst_c & ~rst;
  assign bus.mem2reg  = mem2reg_c & ~rst;
  assign bus.alusrca  = alusrca_c & ~rst;
  assign bus.alusrcb  = rst ? 2'b00 : alusrcb_c;
  assign bus.op       = rst ? 3'b000 : op_c;
  assign bus.state    = rst ? 4'd0 : state_q;
  assign bus.illegal  = illegal_c & ~rst;
  assign bus.timeout  = timeout_c & ~rst;

endmodule

// File: tb/tb_mc_controller.sv
// Cycle-by-cycle vector bench for mc_controller: a trace table of inputs with
// hand-computed state and control words, plus a hand-written timeout sequence.
module tb_mc_controller;

  typedef struct {
    logic        rst;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] w;
  } vec_t;

  // Control word layout, MSB first:
  // iord memread memwrite irwrite pcen pcsrc[2] regwrite regdst mem2reg alusrca alusrcb[2] op[3] illegal timeout
  localparam logic [17:0] IORD = 18'h20000;
  localparam logic [17:0] MRD  = 18'h10000;
  localparam logic [17:0] MWR  = 18'h08000;
  localparam logic [17:0] IRW  = 18'h04000;
  localparam logic [17:0] PCEN = 18'h02000;
  localparam logic [17:0] REGW = 18'h00400;
  localparam logic [17:0] RDST = 18'h00200;
  localparam logic [17:0] M2R  = 18'h00100;
  localparam logic [17:0] ASA  = 18'h00080;
  localparam logic [17:0] ILL  = 18'h00002;
  localparam logic [17:0] TO   = 18'h00001;

  function automatic logic [17:0] psrc(input logic [1:0] v);
    return 18'(v) << 11;
  endfunction
  function automatic logic [17:0] asb(input logic [1:0] v);
    return 18'(v) << 5;
  endfunction
  function automatic logic [17:0] opf(input logic [2:0] v);
    return 18'(v) << 2;
  endfunction

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];

  logic [17:0] w_f0, w_f1, w_dec, w_ma, w_mr, w_mwb, w_mw, w_awb, w_aiwb, w_j;

  mc_controller_if bus();

  mc_controller #(.MEM_WAIT_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] ex(input logic [2:0] o);
    return ASA | opf(o);
  endfunction
  function automatic logic [17:0] br(input logic zz);
    return ASA | opf(3'b110) | psrc(2'b01) | (zz ? PCEN : 18'h0);
  endfunction

  task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic zz, input logic rdy, input logic [3:0] s, input logic [17:0] w);
    vec_t v;
    v.rst = r; v.opc = o; v.fn = f; v.z = zz; v.rdy = rdy; v.st = s; v.w = w;
    vecs.push_back(v);
  endtask

  task automatic step(input vec_t v, input string tag);
    logic [17:0] got;
    @(negedge clk);
    rst           = v.rst;
    bus.opcode    = v.opc;
    bus.funct     = v.fn;
    bus.zero      = v.z;
    bus.mem_ready = v.rdy;
    #1;
    got = {bus.iord, bus.memread, bus.memwrite, bus.irwrite, bus.pcen, bus.pcsrc,
           bus.regwrite, bus.regdst, bus.mem2reg, bus.alusrca, bus.alusrcb, bus.op,
           bus.illegal, bus.timeout};
    total++;
    if (bus.state !== v.st) begin
      bad++;
      $display("FAIL %s state got=%0d want=%0d", tag, bus.state, v.st);
    end
    total++;
    if (got !== v.w) begin
      bad++;
      $display("FAIL %s ctrl got=%05h want=%05h", tag, got, v.w);
    end
  endtask

  initial begin
    logic [5:0] fns [4];
    logic [2:0] ops [4];
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    w_f0   = MRD | asb(2'b01) | opf(3'b010);
    w_f1   = w_f0 | IRW | PCEN;
    w_dec  = asb(2'b11) | opf(3'b010);
    w_ma   = ASA | asb(2'b10) | opf(3'b010);
    w_mr   = MRD | IORD;
    w_mwb  = REGW | M2R;
    w_mw   = MWR | IORD;
    w_awb  = REGW | RDST;
    w_aiwb = REGW;
    w_j    = psrc(2'b10) | PCEN;

    // reset
    add(1, RT, 0, 0, 1, 0, 18'h0);
    // lw, zero-wait: 5 cycles
    add(0, LW, 0, 0, 1, 0, w_f1);
    add(0, LW, 0, 0, 0, 1, w_dec);
    add(0, LW, 0, 0, 1, 2, w_ma);
    add(0, LW, 0, 0, 1, 3, w_mr);
    add(0, LW, 0, 0, 1, 4, w_mwb);
    // R-type sub
    add(0, RT, 6'b100010, 0, 1, 0, w_f1);
    add(0, RT, 6'b100010, 0, 1, 1, w_dec);
    add(0, RT, 6'b100010, 0, 1, 6, ex(3'b110));
    add(0, RT, 6'b100010, 0, 1, 7, w_awb);
    // remaining ALU functs
    fns = '{6'b100000, 6'b100100, 6'b100101, 6'b101010};
    ops = '{3'b010, 3'b000, 3'b001, 3'b111};
    for (int i = 0; i < 4; i++) begin
      add(0, RT, fns[i], 0, 1, 0, w_f1);
      add(0, RT, fns[i], 0, 1, 1, w_dec);
      add(0, RT, fns[i], 0, 1, 6, ex(ops[i]));
      add(0, RT, fns[i], 0, 1, 7, w_awb);
    end
    // beq taken then not taken
    add(0, BEQ, 0, 1, 1, 0, w_f1);
    add(0, BEQ, 0, 1, 1, 1, w_dec);
    add(0, BEQ, 0, 1, 1, 8, br(1'b1));
    add(0, BEQ, 0, 0, 1, 0, w_f1);
    add(0, BEQ, 0, 0, 1, 1, w_dec);
    add(0, BEQ, 0, 0, 1, 8, br(1'b0));
    // addi
    add(0, ADDI, 0, 0, 1, 0, w_f1);
    add(0, ADDI, 0, 0, 1, 1, w_dec);
    add(0, ADDI, 0, 0, 1, 9, w_ma);
    add(0, ADDI, 0, 0, 1, 10, w_aiwb);
    // j
    add(0, JMP, 0, 0, 1, 0, w_f1);
    add(0, JMP, 0, 0, 1, 1, w_dec);
    add(0, JMP, 0, 0, 1, 11, w_j);
    // illegal opcode, then illegal funct
    add(0, 6'b111111, 0, 0, 1, 0, w_f1);
    add(0, 6'b111111, 0, 0, 1, 1, w_dec | ILL);
    add(0, RT, 6'b000000, 0, 1, 0, w_f1);
    add(0, RT, 6'b000000, 0, 1, 1, w_dec);
    add(0, RT, 6'b000000, 0, 1, 6, ASA | ILL);
    // sw with 3 wait cycles; mem_ready low in DECODE/MEMADR is ignored
    add(0, SW, 0, 0, 1, 0, w_f1);
    add(0, SW, 0, 0, 0, 1, w_dec);
    add(0, SW, 0, 0, 0, 2, w_ma);
    add(0, SW, 0, 0, 0, 5, w_mw);
    add(0, SW, 0, 0, 0, 5, w_mw);
    add(0, SW, 0, 0, 0, 5, w_mw);
    add(0, SW, 0, 0, 1, 5, w_mw);
    add(0, SW, 0, 0, 0, 0, w_f0);
    // add, then reset for 2 cycles in EXEC
    add(0, RT, 6'b100000, 0, 1, 0, w_f1);
    add(0, RT, 6'b100000, 0, 1, 1, w_dec);
    add(0, RT, 6'b100000, 0, 1, 6, ex(3'b010));
    add(1, RT, 6'b100000, 0, 1, 0, 18'h0);
    add(1, RT, 6'b100000, 0, 1, 0, 18'h0);
    add(0, RT, 6'b100000, 0, 0, 0, w_f0);

    foreach (vecs[i]) step(vecs[i], $sformatf("row%0d", i));

    // sw with memory never ready: timeout after 15 wait cycles
    begin
      vec_t v;
      v.rst = 0; v.opc = SW; v.fn = 0; v.z = 0;
      v.rdy = 1; v.st = 0; v.w = w_f1;  step(v, "to_fetch");
      v.rdy = 0; v.st = 1; v.w = w_dec; step(v, "to_dec");
      v.st = 2; v.w = w_ma;             step(v, "to_madr");
      for (int k = 0; k < 15; k++) begin
        v.st = 5; v.w = w_mw; step(v, $sformatf("to_wait%0d", k));
      end
      v.st = 5; v.w = w_mw | TO;        step(v, "to_pulse");
      // FETCH entered fresh; it too times out after 15 waits with no pcen/irwrite
      for (int k = 0; k < 15; k++) begin
        v.st = 0; v.w = w_f0; step(v, $sformatf("fto_wait%0d", k));
      end
      v.st = 0; v.w = w_f0 | TO;        step(v, "fto_pulse");
      v.st = 0; v.w = w_f0;             step(v, "fto_after");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
